// File: rtl/yuv_frame_pkg.sv
// yuv_frame_pkg: frame memory layout shared by the YUV frame reader and the
// camera capture writer, plus the reader FSM state encoding.
// Word addresses, 64-bit words, 8 samples per word.
// The chroma planes are (H/2)*(V/2) samples each, which is H*V/32 words.
package yuv_frame_pkg;

   localparam int H_ACTIVE_DFLT   = 640;
   localparam int V_ACTIVE_DFLT   = 480;
   localparam int RD_LATENCY_DFLT = 1;

   function automatic int u_base_of(input int h, input int v);
      return h * v / 8;
   endfunction

   function automatic int v_base_of(input int h, input int v);
      return h * v / 8 + h * v / 32;
   endfunction

   localparam int Y_BASE           = 0;
   localparam int U_BASE           = u_base_of(H_ACTIVE_DFLT, V_ACTIVE_DFLT);   // 38400
   localparam int V_BASE           = v_base_of(H_ACTIVE_DFLT, V_ACTIVE_DFLT);   // 48000
   localparam int Y_WORDS_PER_LINE = H_ACTIVE_DFLT / 8;
   localparam int C_WORDS_PER_LINE = H_ACTIVE_DFLT / 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_U,
      ST_RD_V,
      ST_RD_Y,
      ST_WAIT,
      ST_EMIT,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      CAP_U,
      CAP_V,
      CAP_Y
   } cap_t;

endpackage

// File: rtl/yuv_word_unpacker.sv
// yuv_word_unpacker: holds one 64-bit memory word and presents its samples
// one at a time, lowest byte first. A load replaces the word; a shift moves
// the next sample into the output byte lane.
module yuv_word_unpacker (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic        load,
   input  logic        shift,
   input  logic [63:0] din,
   output logic [7:0]  dout
);

   logic [63:0] word_q;

   // Load a fresh word, or step to the next byte lane.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         word_q <= '0;
      end else if (load) begin
         word_q <= din;
      end else if (shift) begin
         word_q <= {8'h00, word_q[63:8]};
      end
   end

   assign dout = word_q[7:0];

endmodule

// File: rtl/yuv_frame_reader.sv
// yuv_frame_reader: reads one YUV 4:2:0 frame from the camera frame memory
// and streams raster-order Y/U/V pixels with a valid/ready handshake.
// Chroma is replicated 2x horizontally and vertically.
// Build option: define YUV_FRAME_READER_GRAY_EN to fetch luma only and
// drive pix_u = pix_v = 8'd128.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// RD_U    | one-cycle read strobe for the group's U word
// RD_V    | one-cycle read strobe for the group's V word
// RD_Y    | one-cycle read strobe for the next 8 luma samples
// WAIT    | memory latency; captures rd_data on the terminal count
// EMIT    | presents 8 pixels, one per handshake
// DONE    | one-cycle frame_done, then back to IDLE
module yuv_frame_reader
   import yuv_frame_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DFLT,
   parameter int V_ACTIVE   = V_ACTIVE_DFLT,
   parameter int RD_LATENCY = RD_LATENCY_DFLT
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic        start,
   output logic        busy,
   output logic        frame_done,
   output logic        rd_en,
   output logic [15:0] rd_address,
   input  logic [63:0] rd_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic [7:0]  pix_y,
   output logic [7:0]  pix_u,
   output logic [7:0]  pix_v,
   output logic        pix_sof,
   output logic        pix_eol
);

   localparam logic [15:0] Y_BASE_P  = 16'(Y_BASE);
   localparam logic [15:0] U_BASE_P  = 16'(u_base_of(H_ACTIVE, V_ACTIVE));
   localparam logic [15:0] V_BASE_P  = 16'(v_base_of(H_ACTIVE, V_ACTIVE));
   localparam logic [15:0] Y_WPL     = 16'(H_ACTIVE / 8);
   localparam logic [15:0] C_WPL     = 16'(H_ACTIVE / 16);
   localparam logic [9:0]  COL_LAST  = 10'(H_ACTIVE - 1);
   localparam logic [8:0]  ROW_LAST  = 9'(V_ACTIVE - 1);
   localparam logic [1:0]  WAIT_LOAD = 2'(RD_LATENCY - 1);

`ifdef YUV_FRAME_READER_GRAY_EN
   localparam state_t FIRST_RD = ST_RD_Y;
`else
   localparam state_t FIRST_RD = ST_RD_U;
`endif

   // Geometry must fit the 9-bit row, 10-bit col and 16-bit address space.
   if ((H_ACTIVE % 16) != 0 || (V_ACTIVE % 2) != 0 || H_ACTIVE > 1024 ||
       V_ACTIVE > 512 || (H_ACTIVE * V_ACTIVE * 3 / 16) > 65536 ||
       RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_cfg_bad
      $error("yuv_frame_reader: unsupported geometry or read latency");
   end

   state_t      state_q, state_d;
   cap_t        cap_sel_q;
   logic [1:0]  wait_q;
   logic [8:0]  row_q;
   logic [9:0]  col_q;
   logic        hs;
   logic        cap_now;
   logic        grp_end;
   logic        last_px;
   logic [15:0] y_off;
   logic [15:0] c_off;

   assign hs      = (state_q == ST_EMIT) && pix_ready;
   assign cap_now = (state_q == ST_WAIT) && (wait_q == 2'd0);
   assign grp_end = (col_q[2:0] == 3'd7);
   assign last_px = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign y_off   = 16'(row_q) * Y_WPL + 16'(col_q[9:3]);
   assign c_off   = 16'(row_q[8:1]) * C_WPL + 16'(col_q[9:4]);

   // State register.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: U, V, Y(lo), EMIT 8, Y(hi), EMIT 8 per 16-pixel group.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = FIRST_RD;
         ST_RD_U,
         ST_RD_V,
         ST_RD_Y: state_d = ST_WAIT;
         ST_WAIT: begin
            if (wait_q == 2'd0) begin
               case (cap_sel_q)
                  CAP_U:   state_d = ST_RD_V;
                  CAP_V:   state_d = ST_RD_Y;
                  default: state_d = ST_EMIT;
               endcase
            end
         end
         ST_EMIT: begin
            if (hs && grp_end) begin
               if (last_px) begin
                  state_d = ST_DONE;
               end else if (!col_q[3]) begin
                  state_d = ST_RD_Y;
               end else begin
                  state_d = FIRST_RD;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state and pixel position.
   always_comb begin
      busy       = 1'b0;
      frame_done = 1'b0;
      rd_en      = 1'b0;
      rd_address = '0;
      pix_valid  = 1'b0;
      pix_sof    = 1'b0;
      pix_eol    = 1'b0;
      case (state_q)
         ST_RD_U: begin
            busy       = 1'b1;
            rd_en      = 1'b1;
            rd_address = U_BASE_P + c_off;
         end
         ST_RD_V: begin
            busy       = 1'b1;
            rd_en      = 1'b1;
            rd_address = V_BASE_P + c_off;
         end
         ST_RD_Y: begin
            busy       = 1'b1;
            rd_en      = 1'b1;
            rd_address = Y_BASE_P + y_off;
         end
         ST_WAIT: busy = 1'b1;
         ST_EMIT: begin
            busy      = 1'b1;
            pix_valid = 1'b1;
            pix_sof   = (row_q == 9'd0) && (col_q == 10'd0);
            pix_eol   = (col_q == COL_LAST);
         end
         ST_DONE: frame_done = 1'b1;
         default: ;
      endcase
   end

   // Pixel position, capture target and read-latency down-counter.
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         row_q     <= '0;
         col_q     <= '0;
         wait_q    <= '0;
         cap_sel_q <= CAP_Y;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  row_q <= '0;
                  col_q <= '0;
               end
            end
            ST_RD_U: begin
               cap_sel_q <= CAP_U;
               wait_q    <= WAIT_LOAD;
            end
            ST_RD_V: begin
               cap_sel_q <= CAP_V;
               wait_q    <= WAIT_LOAD;
            end
            ST_RD_Y: begin
               cap_sel_q <= CAP_Y;
               wait_q    <= WAIT_LOAD;
            end
            ST_WAIT: begin
               if (wait_q != 2'd0) wait_q <= wait_q - 2'd1;
            end
            ST_EMIT: begin
               if (hs) begin
                  if (col_q == COL_LAST) begin
                     col_q <= '0;
                     row_q <= row_q + 9'd1;
                  end else begin
                     col_q <= col_q + 10'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   yuv_word_unpacker u_unp_y (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .load     (cap_now && (cap_sel_q == CAP_Y)),
      .shift    (hs),
      .din      (rd_data),
      .dout     (pix_y)
   );

`ifdef YUV_FRAME_READER_GRAY_EN
   assign pix_u = 8'd128;
   assign pix_v = 8'd128;
`else
   // One chroma sample spans two pixels, so step on odd columns only.
   yuv_word_unpacker u_unp_u (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .load     (cap_now && (cap_sel_q == CAP_U)),
      .shift    (hs && col_q[0]),
      .din      (rd_data),
      .dout     (pix_u)
   );

   yuv_word_unpacker u_unp_v (
      .CLOCK_50 (CLOCK_50),
      .RESET    (RESET),
      .load     (cap_now && (cap_sel_q == CAP_V)),
      .shift    (hs && col_q[0]),
      .din      (rd_data),
      .dout     (pix_v)
   );
`endif

endmodule

// File: tb/tb_yuv_frame_reader.sv
// tb_yuv_frame_reader: scoreboard bench for yuv_frame_reader on a 32x4 frame.
// Memory: Y words 0..15, U words 16..19, V words 20..23.
module tb_yuv_frame_reader;

   localparam int H    = 32;
   localparam int V    = 4;
   localparam int LAT  = 1;
   localparam int NPX  = H * V;
   localparam int U_B  = 16;
   localparam int V_B  = 20;
   localparam int YWPL = 4;
   localparam int CWPL = 2;

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] u;
      logic [7:0] v;
      logic       sof;
      logic       eol;
   } px_t;

   logic        CLOCK_50  = 1'b0;
   logic        RESET     = 1'b1;
   logic        start     = 1'b0;
   logic        pix_ready = 1'b1;
   logic        busy, frame_done, rd_en;
   logic [15:0] rd_address;
   logic [63:0] rd_data;
   logic        pix_valid, pix_sof, pix_eol;
   logic [7:0]  pix_y, pix_u, pix_v;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_cnt   = 0;
   int eol_cnt  = 0;
   int done_cnt = 0;
   bit bp_en    = 1'b0;
   bit ok;

   px_t         exp_px[$];
   logic [15:0] exp_addr[$];

   logic [63:0] mem [32];
   logic        v1 = 1'b0, v2 = 1'b0;
   logic [15:0] a1 = '0, a2 = '0;
   logic [63:0] junk = '0;

   yuv_frame_reader #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .RD_LATENCY (LAT)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET      (RESET),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .rd_en      (rd_en),
      .rd_address (rd_address),
      .rd_data    (rd_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_y      (pix_y),
      .pix_u      (pix_u),
      .pix_v      (pix_v),
      .pix_sof    (pix_sof),
      .pix_eol    (pix_eol)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Memory model: data is valid only in the capture cycle, junk otherwise.
   always @(posedge CLOCK_50) begin
      v1   <= rd_en;
      a1   <= rd_address;
      v2   <= v1;
      a2   <= a1;
      junk <= {$urandom, $urandom};
   end

   always_comb begin
      rd_data = junk;
      if (LAT == 1) begin
         if (v1) rd_data = mem[a1[4:0]];
      end else begin
         if (v2) rd_data = mem[a2[4:0]];
      end
   end

   // Backpressure driver.
   initial begin
      forever begin
         @(posedge CLOCK_50);
         #1;
         pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_frame();
      px_t p;
      for (int r = 0; r < V; r++) begin
         for (int c = 0; c < H; c++) begin
            p.y = 8'(r * H + c);
`ifdef YUV_FRAME_READER_GRAY_EN
            p.u = 8'd128;
            p.v = 8'd128;
`else
            p.u = 8'(8'h80 + (r / 2) * 16 + c / 2);
            p.v = 8'(8'h90 + (r / 2) * 16 + c / 2);
`endif
            p.sof = (r == 0 && c == 0);
            p.eol = (c == H - 1);
            exp_px.push_back(p);
         end
         for (int g = 0; g < H / 16; g++) begin
`ifndef YUV_FRAME_READER_GRAY_EN
            exp_addr.push_back(16'(U_B + (r / 2) * CWPL + g));
            exp_addr.push_back(16'(V_B + (r / 2) * CWPL + g));
`endif
            exp_addr.push_back(16'(r * YWPL + 2 * g));
            exp_addr.push_back(16'(r * YWPL + 2 * g + 1));
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_rd_en"},      rd_en,      0);
      check({tag, "_rd_address"}, rd_address, 0);
      check({tag, "_pix_valid"},  pix_valid,  0);
      check({tag, "_pix_y"},      pix_y,      0);
`ifdef YUV_FRAME_READER_GRAY_EN
      check({tag, "_pix_uv"},     {pix_u, pix_v}, 16'h8080);
`else
      check({tag, "_pix_uv"},     {pix_u, pix_v}, 16'h0000);
`endif
      check({tag, "_flags"},      {pix_sof, pix_eol}, 0);
   endtask

   // Called at posedge+2; returns at posedge+2.
   task automatic pulse_start();
      start = 1'b1;
      @(posedge CLOCK_50);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      #1;
   endtask

   task automatic wait_done(input int max_cyc, input bit inject_start, output bit got);
      got = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge CLOCK_50);
         if (frame_done) begin
            got = 1'b1;
            if (inject_start) start = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_done_timeout: got no pulse, required one within %0d cycles", max_cyc);
      end
      @(posedge CLOCK_50);
      #2;
      start = 1'b0;
   endtask

   task automatic clear_counts();
      hs_cnt   = 0;
      eol_cnt  = 0;
      done_cnt = 0;
   endtask

   task automatic check_frame_end(input string tag);
      check({tag, "_handshakes"}, hs_cnt,   NPX);
      check({tag, "_eol_count"},  eol_cnt,  V);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_px_left"},    exp_px.size(),   0);
      check({tag, "_addr_left"},  exp_addr.size(), 0);
   endtask

   // Monitor: read addresses, pixel handshakes, stall stability, frame_done.
   initial begin
      px_t  e;
      logic prev_stall = 1'b0;
      logic [26:0] prev_out = '0;
      forever begin
         @(negedge CLOCK_50);
         if (RESET) begin
            prev_stall = 1'b0;
            continue;
         end
         if (rd_en) begin
            if (exp_addr.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL addr_extra: got read of %0h, required no read", rd_address);
            end else begin
               check("rd_address", rd_address, exp_addr.pop_front());
            end
         end
         if (prev_stall) begin
            check("stall_hold", {pix_valid, pix_y, pix_u, pix_v, pix_sof, pix_eol}, prev_out);
         end
         if (pix_valid && pix_ready) begin
            hs_cnt++;
            if (pix_eol) eol_cnt++;
            if (exp_px.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL pixel_extra: got pixel y=%0h, required none", pix_y);
            end else begin
               e = exp_px.pop_front();
               check("pixel", {pix_y, pix_u, pix_v, pix_sof, pix_eol}, e);
            end
         end
         if (frame_done) done_cnt++;
         prev_stall = pix_valid && !pix_ready;
         prev_out   = {pix_valid, pix_y, pix_u, pix_v, pix_sof, pix_eol};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int w = 0; w < 32; w++) begin
         for (int k = 0; k < 8; k++) begin
            if (w < 16)      mem[w][8*k +: 8] = 8'(w * 8 + k);
            else if (w < 20) mem[w][8*k +: 8] = 8'(8'h80 + (w - 16) * 8 + k);
            else if (w < 24) mem[w][8*k +: 8] = 8'(8'h90 + (w - 20) * 8 + k);
            else             mem[w][8*k +: 8] = 8'hEE;
         end
      end

      RESET = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1;
      check_reset_vals("por");
      #1;
      RESET = 1'b0;
      @(posedge CLOCK_50);
      #2;

      // Frame 1: no backpressure, start while busy, start coincident with frame_done.
      clear_counts();
      push_frame();
      pulse_start();
      repeat (30) @(posedge CLOCK_50);
      #2;
      start = 1'b1;
      @(posedge CLOCK_50);
      #2;
      start = 1'b0;
      wait_done(2000, 1'b1, ok);
      repeat (3) @(posedge CLOCK_50);
      #1;
      check("start_at_done_ignored", busy, 0);
      #1;
      check_frame_end("f1");

      // Frame 2: random backpressure, same expected stream.
      clear_counts();
      bp_en = 1'b1;
      push_frame();
      pulse_start();
      wait_done(4000, 1'b0, ok);
      bp_en = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      #2;
      check_frame_end("f2");

      // Frame 3: aborted by reset in the middle of EMIT.
      clear_counts();
      push_frame();
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge CLOCK_50);
         #2;
         if (hs_cnt >= 40 && pix_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("reached_mid_emit", ok, 1);
      exp_px.delete();
      exp_addr.delete();
      RESET = 1'b1;
      #1;
      check_reset_vals("mid");
      repeat (2) @(posedge CLOCK_50);
      #2;
      RESET = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #2;
      check("no_done_after_abort", done_cnt, 0);

      // Frame 4: fresh frame after the abort starts at pixel (0,0).
      clear_counts();
      push_frame();
      pulse_start();
      wait_done(2000, 1'b0, ok);
      repeat (2) @(posedge CLOCK_50);
      #2;
      check_frame_end("f4");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
